// File: rtl/serpent_inv_sbox_seq.sv
// Sequential bitsliced Serpent inverse S-box unit (SI0..SI7).
// Accepts one 128-bit block (four 32-bit words) plus a box index, then
// substitutes SLICES_PER_CYCLE bit-slices per clock. The result is
// returned over a valid/ready handshake.
// Optional feature macro: SERPENT_INV_SBOX_SELFCHECK_EN. When it is
// defined, the unit re-applies the forward S-box to the result and flags
// any mismatch on chk_err.
module serpent_inv_sbox_seq #(
    parameter int SLICES_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_idx,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3,
    output logic        chk_err
);
    localparam int N = 32 / SLICES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx_q;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      nw0, nw1, nw2, nw3;

    // Inverse S-box lookup; nibble k sits at hex digit k counted from the left
    function automatic logic [3:0] inv_sbox(input logic [2:0] idx, input logic [3:0] nib);
        logic [63:0] t;
        case (idx)
            3'd0:    t = 64'hD3B0A65C1E47F982;
            3'd1:    t = 64'h582EF6C3B4791DA0;
            3'd2:    t = 64'hC9F4BE12036D58A7;
            3'd3:    t = 64'h09A7BE6D35C248F1;
            3'd4:    t = 64'h5083A97E2CB64FD1;
            3'd5:    t = 64'h8F2941DEB6537CA0;
            3'd6:    t = 64'hFA1D536049E72C8B;
            default: t = 64'h306D9EF85CB7A142;
        endcase
        return t[(15 - int'(nib)) * 4 +: 4];
    endfunction

    // Next-state decode of the IDLE -> BUSY -> DONE handshake sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)         state_nx = BUSY;
            BUSY:    if (cnt == CNT_LAST)  state_nx = DONE;
            DONE:    if (out_ready)        state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Substitute the group of slices selected by cnt; all others pass through
    always_comb begin
        nw0 = w0;
        nw1 = w1;
        nw2 = w2;
        nw3 = w3;
        for (int j = 0; j < SLICES_PER_CYCLE; j++) begin
            logic [4:0] pos;
            logic [3:0] sub;
            pos = 5'(int'(cnt) * SLICES_PER_CYCLE + j);
            sub = inv_sbox(idx_q, {w3[pos], w2[pos], w1[pos], w0[pos]});
            nw0[pos] = sub[0];
            nw1[pos] = sub[1];
            nw2[pos] = sub[2];
            nw3[pos] = sub[3];
        end
    end

    // Working registers, captured index and slice counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            idx_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    w0    <= x0;
                    w1    <= x1;
                    w2    <= x2;
                    w3    <= x3;
                    idx_q <= in_idx;
                    cnt   <= '0;
                end
                BUSY: begin
                    w0 <= nw0;
                    w1 <= nw1;
                    w2 <= nw2;
                    w3 <= nw3;
                    if (cnt == CNT_LAST) cnt <= '0;
                    else                 cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign y0 = w0;
    assign y1 = w1;
    assign y2 = w2;
    assign y3 = w3;

`ifdef SERPENT_INV_SBOX_SELFCHECK_EN
    logic [31:0] c0, c1, c2, c3;
    logic        mism;

    // Forward S-box lookup, same digit ordering as inv_sbox
    function automatic logic [3:0] fwd_sbox(input logic [2:0] idx, input logic [3:0] nib);
        logic [63:0] t;
        case (idx)
            3'd0:    t = 64'h38F1A65BED42709C;
            3'd1:    t = 64'hFC27905A1BE86D34;
            3'd2:    t = 64'h86793CAFD1E40B52;
            3'd3:    t = 64'h0FB8C963D124A75E;
            3'd4:    t = 64'h1F83C0B6254A9E7D;
            3'd5:    t = 64'hF52B4A9C03E8D671;
            3'd6:    t = 64'h72C5846BE91FD3A0;
            default: t = 64'h1DF0E82B74CA9356;
        endcase
        return t[(15 - int'(nib)) * 4 +: 4];
    endfunction

    // Forward-map the completed block (including this cycle's slices) back to the input
    always_comb begin
        mism = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (fwd_sbox(idx_q, {nw3[i], nw2[i], nw1[i], nw0[i]}) != {c3[i], c2[i], c1[i], c0[i]})
                mism = 1'b1;
        end
    end

    // Input copy and registered mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0      <= '0;
            c1      <= '0;
            c2      <= '0;
            c3      <= '0;
            chk_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            c0      <= x0;
            c1      <= x1;
            c2      <= x2;
            c3      <= x3;
            chk_err <= 1'b0;
        end else if (state == BUSY && cnt == CNT_LAST) begin
            chk_err <= mism;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_serpent_inv_sbox_seq.sv
// Testbench for serpent_inv_sbox_seq: scoreboard of expected blocks,
// compared when the unit presents its result.
module tb_serpent_inv_sbox_seq;
    localparam int SPC = 8;
    localparam int N   = 32 / SPC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_idx = '0;
    logic [31:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y0, y1, y2, y3;
    logic        chk_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [127:0] exp_q[$];
    logic [127:0] got_y;

    serpent_inv_sbox_seq #(.SLICES_PER_CYCLE(SPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [3:0] si_ref(input logic [2:0] idx, input logic [3:0] nib);
        logic [63:0] t;
        case (idx)
            3'd0:    t = 64'hD3B0A65C1E47F982;
            3'd1:    t = 64'h582EF6C3B4791DA0;
            3'd2:    t = 64'hC9F4BE12036D58A7;
            3'd3:    t = 64'h09A7BE6D35C248F1;
            3'd4:    t = 64'h5083A97E2CB64FD1;
            3'd5:    t = 64'h8F2941DEB6537CA0;
            3'd6:    t = 64'hFA1D536049E72C8B;
            default: t = 64'h306D9EF85CB7A142;
        endcase
        return t[(15 - int'(nib)) * 4 +: 4];
    endfunction

    function automatic logic [3:0] s_ref(input logic [2:0] idx, input logic [3:0] nib);
        logic [63:0] t;
        case (idx)
            3'd0:    t = 64'h38F1A65BED42709C;
            3'd1:    t = 64'hFC27905A1BE86D34;
            3'd2:    t = 64'h86793CAFD1E40B52;
            3'd3:    t = 64'h0FB8C963D124A75E;
            3'd4:    t = 64'h1F83C0B6254A9E7D;
            3'd5:    t = 64'hF52B4A9C03E8D671;
            3'd6:    t = 64'h72C5846BE91FD3A0;
            default: t = 64'h1DF0E82B74CA9356;
        endcase
        return t[(15 - int'(nib)) * 4 +: 4];
    endfunction

    // Block packing is {w3, w2, w1, w0}; fwd selects the forward box
    function automatic logic [127:0] blk_map(input logic [2:0] idx, input logic [127:0] x, input bit fwd);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            logic [3:0] nb, s;
            nb = {x[96+i], x[64+i], x[32+i], x[i]};
            s  = fwd ? s_ref(idx, nb) : si_ref(idx, nb);
            r[i] = s[0]; r[32+i] = s[1]; r[64+i] = s[2]; r[96+i] = s[3];
        end
        return r;
    endfunction

    task automatic accept(input logic [2:0] idx, input logic [127:0] xin);
        int t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check_eq("in_ready_timeout", 128'd0, 128'd1);
        in_idx = idx;
        {x3, x2, x1, x0} = xin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_idx = 3'($urandom);
        x0 = $urandom; x1 = $urandom; x2 = $urandom; x3 = $urandom;
        exp_q.push_back(blk_map(idx, xin, 1'b0));
    endtask

    task automatic collect(input int hold);
        int lat = 0;
        bit stable = 1'b1;
        logic [127:0] e;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("latency", 128'(lat), 128'(N));
        check_eq("in_ready_in_done", 128'(in_ready), 128'd0);
        got_y = {y3, y2, y1, y0};
        if (exp_q.size() == 0) check_eq("scoreboard_empty", 128'd1, 128'd0);
        else begin
            e = exp_q.pop_front();
            check_eq("y", got_y, e);
        end
        check_eq("chk_err", 128'(chk_err), 128'd0);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                in_valid = k[0];
                in_idx = 3'($urandom);
                x0 = $urandom; x1 = $urandom;
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || {y3, y2, y1, y0} !== got_y) stable = 1'b0;
            end
            in_valid = 1'b0;
            check_eq("hold_stable", 128'(stable), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_out_valid", 128'(out_valid), 128'd0);
        check_eq("release_in_ready", 128'(in_ready), 128'd1);
        check_eq("release_y_kept", {y3, y2, y1, y0}, got_y);
    endtask

    initial begin
        logic [127:0] xr;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_y", {y3, y2, y1, y0}, 128'd0);
        check_eq("rst_chk_err", 128'(chk_err), 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // SI0 of all-zero input
        accept(3'd0, 128'd0);
        collect(0);
        check_eq("t1_const", got_y, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);

        // SI7 of all-ones input
        accept(3'd7, {128{1'b1}});
        collect(0);
        check_eq("t2_const", got_y, 128'h00000000_00000000_FFFFFFFF_00000000);

        // SI3 with only slice 0 = 1
        accept(3'd3, 128'h00000000_00000000_00000000_00000001);
        collect(0);
        check_eq("t3_const", got_y, 128'h00000001_00000000_00000000_00000001);

        // Sweep all boxes with random data; forward box must restore input
        for (int b = 0; b < 8; b++) begin
            xr = {$urandom, $urandom, $urandom, $urandom};
            accept(3'(b), xr);
            collect(0);
            check_eq("fwd_roundtrip", blk_map(3'(b), got_y, 1'b1), xr);
        end

        // Backpressure in DONE with ignored in_valid pulses
        xr = {$urandom, $urandom, $urandom, $urandom};
        accept(3'd5, xr);
        collect(10);

        // Asynchronous reset two edges after accept
        accept(3'd2, {$urandom, $urandom, $urandom, $urandom});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 128'(out_valid), 128'd0);
        check_eq("arst_in_ready", 128'(in_ready), 128'd1);
        check_eq("arst_y", {y3, y2, y1, y0}, 128'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        xr = {$urandom, $urandom, $urandom, $urandom};
        accept(3'd6, xr);
        collect(2);
        check_eq("post_rst_roundtrip", blk_map(3'd6, got_y, 1'b1), xr);

        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
